// File: rtl/ysyx_22051013_axi_rr_arbiter.sv
// Round-robin arbiter that funnels NREQ simple request/response ports onto a
// single AXI4 master port, keeping exactly one transaction in flight.
module ysyx_22051013_axi_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 64,
  parameter int DW   = 64,
  parameter int IDW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // requester side
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DW-1:0]     req_wdata,
  input  logic [NREQ*(DW/8)-1:0] req_wstrb,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DW-1:0]          resp_rdata,
  output logic                   resp_err,
  // AXI write address
  output logic [IDW-1:0]         aw_id,
  output logic [AW-1:0]          aw_addr,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  // AXI write data
  output logic [DW-1:0]          w_data,
  output logic [DW/8-1:0]        w_strb,
  output logic                   w_valid,
  input  logic                   w_ready,
  // AXI write response
  input  logic [IDW-1:0]         b_id,
  input  logic [1:0]             b_resp,
  input  logic                   b_valid,
  output logic                   b_ready,
  // AXI read address
  output logic [IDW-1:0]         ar_id,
  output logic [AW-1:0]          ar_addr,
  output logic                   ar_valid,
  input  logic                   ar_ready,
  // AXI read data
  input  logic [IDW-1:0]         r_id,
  input  logic [DW-1:0]          r_data,
  input  logic [1:0]             r_resp,
  input  logic                   r_valid,
  output logic                   r_ready
);

  localparam int SW = DW / 8;
  // pointer/index width; a single requester still needs a 1-bit vector
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   cur_idx;
  logic            cur_we;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic [SW-1:0]   cur_wstrb;
  logic            aw_done;
  logic            w_done;

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic [IDW-1:0]  cur_id;
  logic            aw_hs;
  logic            w_hs;

  assign cur_id = IDW'(cur_idx);

  // Channel controls decode straight from the state register so each valid
  // stays up until its handshake and AR/AW can never overlap.
  assign ar_valid = (state == S_AR);
  assign r_ready  = (state == S_R);
  assign aw_valid = (state == S_WR) && !aw_done;
  assign w_valid  = (state == S_WR) && !w_done;
  assign b_ready  = (state == S_B);

  assign ar_id   = cur_id;
  assign aw_id   = cur_id;
  assign ar_addr = cur_addr;
  assign aw_addr = cur_addr;
  assign w_data  = cur_wdata;
  assign w_strb  = cur_wstrb;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  // Find the first active requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((32'(rr_ptr) + 32'(i)) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grant pulse is combinational so the accept cycle is the IDLE cycle itself.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  // Transaction sequencer: grant, address phase(s), response, back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cur_wstrb  <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (grant_found) begin
            cur_idx   <= grant_idx;
            cur_we    <= req_we[grant_idx];
            cur_addr  <= req_addr[int'(grant_idx)*AW +: AW];
            cur_wdata <= req_wdata[int'(grant_idx)*DW +: DW];
            cur_wstrb <= req_wstrb[int'(grant_idx)*SW +: SW];
            rr_ptr    <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= req_we[grant_idx] ? S_WR : S_AR;
          end
        end
        S_AR: begin
          if (ar_ready) begin
            state <= S_R;
          end
        end
        S_R: begin
          if (r_valid && r_id == cur_id) begin
            resp_rdata <= r_data;
            resp_err   <= (r_resp != 2'b00);
            resp_valid <= NREQ'(1) << cur_idx;
            state      <= S_IDLE;
          end
        end
        S_WR: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= S_B;
          end else begin
            if (aw_hs) begin
              aw_done <= 1'b1;
            end
            if (w_hs) begin
              w_done <= 1'b1;
            end
          end
        end
        S_B: begin
          if (b_valid && b_id == cur_id) begin
            resp_err   <= (b_resp != 2'b00);
            resp_valid <= NREQ'(1) << cur_idx;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_axi_rr_arbiter.sv
// Testbench for ysyx_22051013_axi_rr_arbiter: random requesters and a random
// AXI slave, every cycle compared against a transaction-level reference model.
module tb_ysyx_22051013_axi_rr_arbiter;

  localparam int NREQ = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IDW = 4;
  localparam int SW = DW / 8;
  localparam int RAND_CYCLES = 3000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*SW-1:0]   req_wstrb;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [DW-1:0]        resp_rdata;
  logic                 resp_err;
  logic [IDW-1:0]       aw_id;
  logic [AW-1:0]        aw_addr;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [DW-1:0]        w_data;
  logic [SW-1:0]        w_strb;
  logic                 w_valid;
  logic                 w_ready;
  logic [IDW-1:0]       b_id;
  logic [1:0]           b_resp;
  logic                 b_valid;
  logic                 b_ready;
  logic [IDW-1:0]       ar_id;
  logic [AW-1:0]        ar_addr;
  logic                 ar_valid;
  logic                 ar_ready;
  logic [IDW-1:0]       r_id;
  logic [DW-1:0]        r_data;
  logic [1:0]           r_resp;
  logic                 r_valid;
  logic                 r_ready;

  always #5 clk = ~clk;

  ysyx_22051013_axi_rr_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  int n_checks = 0;
  int n_bad = 0;
  // 0: fully random, 1: steer into a stalled write, 2: quiet with stray responses
  int mode = 0;

  // requester view: a pending request and the payload it holds
  bit            pend    [NREQ];
  bit            p_we    [NREQ];
  logic [AW-1:0] p_addr  [NREQ];
  logic [DW-1:0] p_wdata [NREQ];
  logic [SW-1:0] p_wstrb [NREQ];

  // reference model: one transaction in flight, described by what is still owed
  bit              m_busy;
  int              m_cur;
  bit              m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  bit              m_addr_left;
  bit              m_data_left;
  int              m_ptr;
  logic [NREQ-1:0] m_resp_valid;
  logic [DW-1:0]   m_rdata;
  bit              m_err;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int pickWinner();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = 0;
    m_cur = 0;
    m_we = 0;
    m_addr_left = 0;
    m_data_left = 0;
    m_ptr = 0;
    m_resp_valid = '0;
    m_rdata = '0;
    m_err = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
  endtask

  // Drive requesters and the slave for the coming clock edge.
  task automatic applyStimulus();
    int roll;
    logic [IDW-1:0] rid;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && ((mode == 0 && $urandom_range(0, 9) < 4) || (mode == 1 && i == 0))) begin
        pend[i]    = 1;
        p_we[i]    = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        p_addr[i]  = rand64();
        p_wdata[i] = rand64();
        p_wstrb[i] = SW'($urandom);
      end
      req_valid[i] = pend[i];
      req_we[i] = pend[i] ? p_we[i] : 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW] = pend[i] ? p_addr[i] : rand64();
      req_wdata[i*DW +: DW] = pend[i] ? p_wdata[i] : rand64();
      req_wstrb[i*SW +: SW] = pend[i] ? p_wstrb[i] : SW'($urandom);
    end
    ar_ready = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    aw_ready = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    w_ready  = 1'($urandom_range(0, 1));
    r_valid = 0;
    r_id = IDW'($urandom);
    r_data = rand64();
    r_resp = 2'($urandom);
    b_valid = 0;
    b_id = IDW'($urandom);
    b_resp = 2'($urandom);
    if (mode == 2) begin
      r_valid = 1;
      r_id = '0;
      b_valid = 1;
      b_id = '0;
    end else if (m_busy && !m_addr_left && !m_data_left) begin
      roll = $urandom_range(0, 9);
      if (roll >= 3) begin
        rid = IDW'(m_cur);
        if (roll == 3 && mode == 0) rid = rid ^ IDW'($urandom_range(1, 15));
        if (m_we) begin
          b_valid = 1;
          b_id = rid;
        end else begin
          r_valid = 1;
          r_id = rid;
        end
      end
    end
  endtask

  // Compare every DUT output against what the model says this cycle shows.
  task automatic checkCycle();
    int win;
    logic [NREQ-1:0] exp_ready;
    win = pickWinner();
    exp_ready = '0;
    if (!m_busy && win >= 0) exp_ready[win] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("resp_valid", 64'(resp_valid), 64'(m_resp_valid));
    checkOutput("resp_rdata", resp_rdata, m_rdata);
    checkOutput("resp_err", 64'(resp_err), 64'(m_err));
    checkOutput("ar_valid", 64'(ar_valid), 64'(m_busy && !m_we && m_addr_left));
    checkOutput("r_ready", 64'(r_ready), 64'(m_busy && !m_we && !m_addr_left));
    checkOutput("aw_valid", 64'(aw_valid), 64'(m_busy && m_we && m_addr_left));
    checkOutput("w_valid", 64'(w_valid), 64'(m_busy && m_we && m_data_left));
    checkOutput("b_ready", 64'(b_ready), 64'(m_busy && m_we && !m_addr_left && !m_data_left));
    if (m_busy && !m_we && m_addr_left) begin
      checkOutput("ar_id", 64'(ar_id), 64'(m_cur));
      checkOutput("ar_addr", ar_addr, m_addr);
    end
    if (m_busy && m_we && m_addr_left) begin
      checkOutput("aw_id", 64'(aw_id), 64'(m_cur));
      checkOutput("aw_addr", aw_addr, m_addr);
    end
    if (m_busy && m_we && m_data_left) begin
      checkOutput("w_data", w_data, m_wdata);
      checkOutput("w_strb", 64'(w_strb), 64'(m_wstrb));
    end
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic advanceModel();
    int win;
    win = pickWinner();
    m_resp_valid = '0;
    if (rst) begin
      modelReset();
      return;
    end
    if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1;
        m_cur = win;
        m_we = p_we[win];
        m_addr = p_addr[win];
        m_wdata = p_wdata[win];
        m_wstrb = p_wstrb[win];
        m_addr_left = 1;
        m_data_left = p_we[win];
        m_ptr = (win + 1) % NREQ;
        pend[win] = 0;
      end
    end else if (m_addr_left || m_data_left) begin
      if (m_we) begin
        if (aw_ready) m_addr_left = 0;
        if (w_ready) m_data_left = 0;
      end else if (ar_ready) begin
        m_addr_left = 0;
      end
    end else if (!m_we && r_valid && r_id == IDW'(m_cur)) begin
      m_busy = 0;
      m_resp_valid[m_cur] = 1'b1;
      m_rdata = r_data;
      m_err = (r_resp != 2'b00);
    end else if (m_we && b_valid && b_id == IDW'(m_cur)) begin
      m_busy = 0;
      m_resp_valid[m_cur] = 1'b1;
      m_err = (b_resp != 2'b00);
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkCycle();
    advanceModel();
  endtask

  // Everything the arbiter drives must read back as zero straight after reset.
  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    checkOutput({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
    checkOutput({pfx, "_resp_rdata"}, resp_rdata, 64'd0);
    checkOutput({pfx, "_resp_err"}, 64'(resp_err), 64'd0);
    checkOutput({pfx, "_ar_valid"}, 64'(ar_valid), 64'd0);
    checkOutput({pfx, "_ar_id"}, 64'(ar_id), 64'd0);
    checkOutput({pfx, "_ar_addr"}, ar_addr, 64'd0);
    checkOutput({pfx, "_aw_valid"}, 64'(aw_valid), 64'd0);
    checkOutput({pfx, "_aw_id"}, 64'(aw_id), 64'd0);
    checkOutput({pfx, "_aw_addr"}, aw_addr, 64'd0);
    checkOutput({pfx, "_w_valid"}, 64'(w_valid), 64'd0);
    checkOutput({pfx, "_w_data"}, w_data, 64'd0);
    checkOutput({pfx, "_w_strb"}, 64'(w_strb), 64'd0);
    checkOutput({pfx, "_r_ready"}, 64'(r_ready), 64'd0);
    checkOutput({pfx, "_b_ready"}, 64'(b_ready), 64'd0);
  endtask

  initial begin
    int guard;
    rst = 1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    aw_ready = 0; w_ready = 0; ar_ready = 0;
    b_id = '0; b_resp = '0; b_valid = 0;
    r_id = '0; r_data = '0; r_resp = '0; r_valid = 0;
    modelReset();
    $display("[TB] start");
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("rst");
    rst = 0;

    mode = 0;
    repeat (RAND_CYCLES) runCycle();

    mode = 1;
    guard = 0;
    while (!(m_busy && m_we && m_addr_left) && guard < 200) begin
      runCycle();
      guard++;
    end
    checkOutput("reach_wr", 64'(m_busy && m_we && m_addr_left), 64'd1);

    @(negedge clk);
    mode = 2;
    applyStimulus();
    rst = 1;
    #1;
    checkCycle();
    advanceModel();
    @(negedge clk);
    rst = 0;
    applyStimulus();
    #1;
    checkAllZero("mid_rst");
    advanceModel();
    repeat (20) runCycle();

    mode = 0;
    repeat (300) runCycle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
